mastermind_vga_pipe: RTL

Parametrised, pipelined successor to the Mastermind board renderer. It converts the current beam position into 12-bit RGB for a ROWS×COLS peg grid with an optional feedback-pip column and a blinking current-row cursor. Board state is snapshotted once per frame so the picture never tears. It sits between `display_controller` (which supplies `bright`, `hCount` and `vCount`) and the VGA DAC pins.

---
 rtl/mastermind_vga_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mastermind_vga_pipe.sv
// mastermind_vga_pipe: pipelined Mastermind board renderer.
// Converts the beam position (bright, hCount, vCount) into 12-bit RGB. The
// peg grid and the feedback pips are drawn from per-frame shadow copies of
// the board state. Output latency is exactly 3 clk.
// Optional feature macro: FEEDBACK_PIPS_EN (feedback pip column).
module mastermind_vga_pipe #(
    parameter int ROWS       = 6,
    parameter int COLS       = 4,
    parameter int CBITS      = 3,
    parameter int SLOT_W     = 48,
    parameter int SLOT_H     = 48,
    parameter int MARGIN     = 16,
    parameter int X0         = 64,
    parameter int Y0         = 32,
    parameter int RADIUS     = 16,
    parameter int V_ACTIVE   = 480,
    parameter int BLINK_LOG2 = 5,
    localparam int FBW       = $clog2(COLS + 1),
    localparam int GW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bright,
    input  logic [9:0]                  hCount,
    input  logic [9:0]                  vCount,
    input  logic [ROWS*COLS*CBITS-1:0]  board,
    input  logic [ROWS*FBW-1:0]         fb_exact,
    input  logic [ROWS*FBW-1:0]         fb_part,
    input  logic [GW-1:0]               guess_num,
    input  logic                        q_Input,
    output logic [3:0]                  vgaR,
    output logic [3:0]                  vgaG,
    output logic [3:0]                  vgaB
);

    localparam int PITCH_X = SLOT_W + MARGIN;
    localparam int PITCH_Y = SLOT_H + MARGIN;
    localparam int BIDX_W  = (ROWS * COLS * CBITS > 1) ? $clog2(ROWS * COLS * CBITS) : 1;

    localparam logic [10:0] X0_C    = 11'(X0);
    localparam logic [10:0] X_END_C = 11'(X0 + COLS * PITCH_X);
    localparam logic [10:0] Y0_C    = 11'(Y0);
    localparam logic [10:0] Y_END_C = 11'(Y0 + ROWS * PITCH_Y);
    localparam logic [10:0] PX_C    = 11'(PITCH_X);
    localparam logic [10:0] PY_C    = 11'(PITCH_Y);
    localparam logic [10:0] SW_C    = 11'(SLOT_W);
    localparam logic [10:0] SH_C    = 11'(SLOT_H);
    localparam logic [10:0] SW2_C   = 11'(SLOT_W - 2);
    localparam logic [10:0] SH2_C   = 11'(SLOT_H - 2);
    localparam logic [9:0]  VACT_C  = 10'(V_ACTIVE);

    localparam logic signed [23:0] HALF_W_C = 24'(SLOT_W / 2);
    localparam logic signed [23:0] HALF_H_C = 24'(SLOT_H / 2);
    localparam logic signed [23:0] RAD2_C   = 24'(RADIUS * RADIUS);

    localparam logic [11:0] C_BLACK = 12'h000;
    localparam logic [11:0] C_WHITE = 12'hFFF;
    localparam logic [11:0] C_GREY  = 12'h888;
    localparam logic [11:0] C_RED   = 12'hF00;
    localparam logic [11:0] C_DIM   = 12'h444;

    // Peg code to 12-bit colour; empty and undefined codes render grey.
    function automatic logic [11:0] peg_colour(input logic [CBITS-1:0] code);
        logic [11:0] c;
        case (32'(code))
            32'd1:   c = 12'h00F;
            32'd2:   c = 12'h0F0;
            32'd3:   c = 12'h0FF;
            32'd4:   c = 12'hF00;
            32'd5:   c = 12'hFF0;
            32'd6:   c = 12'hF0F;
            default: c = C_GREY;
        endcase
        return c;
    endfunction

    // ---------------- shadow state ----------------
    logic                       snap_s;
    logic [ROWS*COLS*CBITS-1:0] sh_board_r;
    logic [GW-1:0]              sh_guess_r;
    logic                       sh_q_r;
    logic [BLINK_LOG2-1:0]      frame_cnt_r;

    assign snap_s = (vCount == VACT_C) && (hCount == 10'd0);

    // Capture board state once per frame on the first invisible line and advance the blink counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_board_r  <= {(ROWS*COLS*CBITS){1'b0}};
            sh_guess_r  <= {GW{1'b0}};
            sh_q_r      <= 1'b0;
            frame_cnt_r <= {BLINK_LOG2{1'b0}};
        end else if (snap_s) begin
            sh_board_r  <= board;
            sh_guess_r  <= guess_num;
            sh_q_r      <= q_Input;
            frame_cnt_r <= frame_cnt_r + {{(BLINK_LOG2-1){1'b0}}, 1'b1};
        end else begin
            sh_board_r  <= sh_board_r;
            sh_guess_r  <= sh_guess_r;
            sh_q_r      <= sh_q_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

`ifdef FEEDBACK_PIPS_EN
    localparam int FIDX_W = (ROWS * FBW > 1) ? $clog2(ROWS * FBW) : 1;
    localparam logic [10:0] FB_X_C   = 11'(X0 + COLS * PITCH_X);
    localparam logic [10:0] FB_END_C = 11'(X0 + COLS * PITCH_X + 12 * COLS);
    localparam logic [10:0] PIP_P_C  = 11'd12;
    localparam logic [10:0] PIP_W_C  = 11'd8;
    localparam logic [10:0] PIP_Y0_C = 11'd20;
    localparam logic [10:0] PIP_Y1_C = 11'd28;
    localparam logic [FBW-1:0] COLS_F_C = FBW'(COLS);
    localparam logic [FBW:0]   COLS_S_C = (FBW+1)'(COLS);

    logic [ROWS*FBW-1:0] sh_exact_r;
    logic [ROWS*FBW-1:0] sh_part_r;

    // Feedback counts share the per-frame snapshot with the board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_exact_r <= {(ROWS*FBW){1'b0}};
            sh_part_r  <= {(ROWS*FBW){1'b0}};
        end else if (snap_s) begin
            sh_exact_r <= fb_exact;
            sh_part_r  <= fb_part;
        end else begin
            sh_exact_r <= sh_exact_r;
            sh_part_r  <= sh_part_r;
        end
    end
`else
    logic unused_fb_s;
    assign unused_fb_s = ^{fb_exact, fb_part};
`endif

    // ---------------- stage 1: grid hit test ----------------
    logic [10:0] hx_s, vy_s, x_off_s, y_off_s;
    logic [10:0] col_s, row_s, dx_s, dy_s;
    logic        in_x_s, in_y_s, in_cell_s;

    logic        bright_1_r, in_cell_1_r;
    logic [10:0] col_1_r, row_1_r, dx_1_r, dy_1_r;

    // Locate the beam in the cell grid: cell indices and offsets inside the cell.
    always_comb begin
        hx_s    = {1'b0, hCount};
        vy_s    = {1'b0, vCount};
        x_off_s = hx_s - X0_C;
        y_off_s = vy_s - Y0_C;
        in_x_s  = (hx_s >= X0_C) && (hx_s < X_END_C);
        in_y_s  = (vy_s >= Y0_C) && (vy_s < Y_END_C);
        dx_s    = x_off_s % PX_C;
        dy_s    = y_off_s % PY_C;
        if (in_x_s) begin
            col_s = x_off_s / PX_C;
        end else begin
            col_s = 11'd0;
        end
        if (in_y_s) begin
            row_s = y_off_s / PY_C;
        end else begin
            row_s = 11'd0;
        end
        in_cell_s = in_x_s && in_y_s && (dx_s < SW_C) && (dy_s < SH_C);
    end

`ifdef FEEDBACK_PIPS_EN
    logic [10:0] fx_off_s, pip_s, pip_mod_s;
    logic        pip_box_s;
    logic [10:0] pip_1_r;
    logic        pip_box_1_r;

    // Pip-column hit test: which pip slot and whether the beam is inside its square.
    always_comb begin
        fx_off_s  = hx_s - FB_X_C;
        pip_s     = fx_off_s / PIP_P_C;
        pip_mod_s = fx_off_s % PIP_P_C;
        if ((hx_s >= FB_X_C) && (hx_s < FB_END_C) && in_y_s) begin
            pip_box_s = (pip_mod_s < PIP_W_C) && (dy_s >= PIP_Y0_C) && (dy_s < PIP_Y1_C);
        end else begin
            pip_box_s = 1'b0;
        end
    end

    // Stage-1 pip registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pip_1_r     <= 11'd0;
            pip_box_1_r <= 1'b0;
        end else begin
            pip_1_r     <= pip_s;
            pip_box_1_r <= pip_box_s;
        end
    end
`endif

    // Stage-1 registers: qualifier and cell geometry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_1_r  <= 1'b0;
            in_cell_1_r <= 1'b0;
            col_1_r     <= 11'd0;
            row_1_r     <= 11'd0;
            dx_1_r      <= 11'd0;
            dy_1_r      <= 11'd0;
        end else begin
            bright_1_r  <= bright;
            in_cell_1_r <= in_cell_s;
            col_1_r     <= col_s;
            row_1_r     <= row_s;
            dx_1_r      <= dx_s;
            dy_1_r      <= dy_s;
        end
    end

    // ---------------- stage 2: peg circle, cursor, fetch ----------------
    logic signed [23:0] ddx_s, ddy_s, dist2_s;
    logic               peg_hit_s, border_s, cursor_row_s;
    logic [BIDX_W-1:0]  bidx_s;
    logic [CBITS-1:0]   code_s;

    logic               bright_2_r, in_cell_2_r, peg_hit_2_r, cursor_2_r;
    logic [CBITS-1:0]   code_2_r;

    // Circle test against the cell centre, peg-code fetch and cursor border detection.
    always_comb begin
        ddx_s     = $signed({13'd0, dx_1_r}) - HALF_W_C;
        ddy_s     = $signed({13'd0, dy_1_r}) - HALF_H_C;
        dist2_s   = (ddx_s * ddx_s) + (ddy_s * ddy_s);
        peg_hit_s = (dist2_s <= RAD2_C);
        bidx_s    = BIDX_W'((int'(row_1_r) * COLS + int'(col_1_r)) * CBITS);
        if (in_cell_1_r) begin
            code_s = sh_board_r[bidx_s +: CBITS];
        end else begin
            code_s = {CBITS{1'b0}};
        end
        border_s = (dx_1_r < 11'd2) || (dx_1_r >= SW2_C) ||
                   (dy_1_r < 11'd2) || (dy_1_r >= SH2_C);
        if ((int'(sh_guess_r) < ROWS) && sh_q_r && !frame_cnt_r[BLINK_LOG2-1]) begin
            cursor_row_s = (int'(row_1_r) == int'(sh_guess_r));
        end else begin
            cursor_row_s = 1'b0;
        end
    end

    // Stage-2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_2_r  <= 1'b0;
            in_cell_2_r <= 1'b0;
            peg_hit_2_r <= 1'b0;
            cursor_2_r  <= 1'b0;
            code_2_r    <= {CBITS{1'b0}};
        end else begin
            bright_2_r  <= bright_1_r;
            in_cell_2_r <= in_cell_1_r;
            peg_hit_2_r <= peg_hit_s;
            cursor_2_r  <= cursor_row_s && border_s;
            code_2_r    <= code_s;
        end
    end

`ifdef FEEDBACK_PIPS_EN
    logic [FIDX_W-1:0] fidx_s;
    logic [FBW-1:0]    ex_s, pt_s, ex_sat_s;
    logic [FBW:0]      sum_s, lim_s;
    logic [1:0]        pip_cls_s;
    logic [1:0]        pip_cls_2_r;

    // Classify the pip: 0 none, 1 exact (red), 2 partial (white), 3 miss (dim).
    always_comb begin
        fidx_s = FIDX_W'(int'(row_1_r) * FBW);
        ex_s   = sh_exact_r[fidx_s +: FBW];
        pt_s   = sh_part_r[fidx_s +: FBW];
        sum_s  = {1'b0, ex_s} + {1'b0, pt_s};
        if (ex_s > COLS_F_C) begin
            ex_sat_s = COLS_F_C;
        end else begin
            ex_sat_s = ex_s;
        end
        if (sum_s > COLS_S_C) begin
            lim_s = COLS_S_C;
        end else begin
            lim_s = sum_s;
        end
        if (!pip_box_1_r || (int'(row_1_r) >= int'(sh_guess_r))) begin
            pip_cls_s = 2'd0;
        end else if (int'(pip_1_r) < int'(ex_sat_s)) begin
            pip_cls_s = 2'd1;
        end else if (int'(pip_1_r) < int'(lim_s)) begin
            pip_cls_s = 2'd2;
        end else begin
            pip_cls_s = 2'd3;
        end
    end

    // Stage-2 pip class register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pip_cls_2_r <= 2'd0;
        end else begin
            pip_cls_2_r <= pip_cls_s;
        end
    end
`endif

    // ---------------- stage 3: colour select ----------------
    logic [11:0] colour_s;
    logic [11:0] rgb_r;

    // Final colour priority: blanking, peg, cursor border, feedback pip, background.
    always_comb begin
        colour_s = C_BLACK;
        if (!bright_2_r) begin
            colour_s = C_BLACK;
        end else if (in_cell_2_r) begin
            if (peg_hit_2_r) begin
                colour_s = peg_colour(code_2_r);
            end else if (cursor_2_r) begin
                colour_s = C_WHITE;
            end else begin
                colour_s = C_BLACK;
            end
        end else begin
`ifdef FEEDBACK_PIPS_EN
            case (pip_cls_2_r)
                2'd1:    colour_s = C_RED;
                2'd2:    colour_s = C_WHITE;
                2'd3:    colour_s = C_DIM;
                default: colour_s = C_BLACK;
            endcase
`else
            colour_s = C_BLACK;
`endif
        end
    end

    // Registered RGB outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= colour_s;
        end
    end

    assign vgaR = rgb_r[11:8];
    assign vgaG = rgb_r[7:4];
    assign vgaB = rgb_r[3:0];

endmodule
